// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard control for the 5-stage MIPS pipeline. It provides:
//   - E-stage and D-stage operand forwarding selects
//   - load-use and branch/jr stalls
//   - a one-entry scoreboard for a multi-cycle multiply/divide (MDU) op
//   - saturating stall-cycle counters, one per stall cause
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   rs_d_i, rt_d_i                    D-stage source registers
//   branch_d_i, pc_src_d_i, jump_d_i  D-stage branch / jump control
//   md_start_d_i                      D holds an MDU instruction
//   rs_e_i, rt_e_i, write_reg_e_i     E-stage register indices
//   mem_to_reg_e_i, reg_write_e_i     E-stage control
//   md_start_e_i, md_dest_e_i         MDU issue from E and its destination
//   write_reg_m_i, mem_to_reg_m_i,
//   reg_write_m_i                     M-stage destination and control
//   write_reg_w_i, reg_write_w_i      W-stage destination and control
//   perf_clr_i                        synchronous clear of all counters
//   stall_f_o, stall_d_o              fetch / decode stall
//   flush_d_o, flush_e_o              decode / execute flush
//   forward_a_d_o, forward_b_d_o      D-stage forward from M
//   forward_a_e_o, forward_b_e_o      E-stage forward (10 M, 01 W, 00 none)
//   stall_cause_o                     0 none, 1 lw, 2 branch, 3 sb, 4 struct
//   md_busy_o, md_done_o              MDU outstanding / result written now
//   perf_lw_o, perf_br_o,
//   perf_sb_o, perf_st_o              per-cause stall-cycle counters
//
// MDU FSM:
//   state | meaning
//   IDLE  | no MDU op outstanding
//   BUSY  | op outstanding; cnt counts down, cnt == 0 is the write-back cycle

module hazard_scoreboard_unit #(
    parameter int ADDR_W     = 6,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs_d_i,
    input  logic [ADDR_W-1:0] rt_d_i,
    input  logic [1:0]        branch_d_i,
    input  logic              pc_src_d_i,
    input  logic [2:0]        jump_d_i,
    input  logic              md_start_d_i,
    input  logic [ADDR_W-1:0] rs_e_i,
    input  logic [ADDR_W-1:0] rt_e_i,
    input  logic [ADDR_W-1:0] write_reg_e_i,
    input  logic              mem_to_reg_e_i,
    input  logic              reg_write_e_i,
    input  logic              md_start_e_i,
    input  logic [ADDR_W-1:0] md_dest_e_i,
    input  logic [ADDR_W-1:0] write_reg_m_i,
    input  logic              mem_to_reg_m_i,
    input  logic              reg_write_m_i,
    input  logic [ADDR_W-1:0] write_reg_w_i,
    input  logic              reg_write_w_i,
    input  logic              perf_clr_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              forward_a_d_o,
    output logic              forward_b_d_o,
    output logic [1:0]        forward_a_e_o,
    output logic [1:0]        forward_b_e_o,
    output logic [2:0]        stall_cause_o,
    output logic              md_busy_o,
    output logic              md_done_o,
    output logic [CNT_W-1:0]  perf_lw_o,
    output logic [CNT_W-1:0]  perf_br_o,
    output logic [CNT_W-1:0]  perf_sb_o,
    output logic [CNT_W-1:0]  perf_st_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MD_LATENCY - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] pend_dest;

    logic lw_stall, br_stall, sb_stall, st_stall;
    logic is_branch, br_hit_e, br_hit_m;

    // Nonzero source that names the given destination.
    function automatic logic src_hit(input logic [ADDR_W-1:0] src,
                                     input logic [ADDR_W-1:0] dest);
        return (src != '0) && (src == dest);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [ADDR_W-1:0] src);
        if (reg_write_m_i && src_hit(src, write_reg_m_i))
            return 2'b10;
        else if (reg_write_w_i && src_hit(src, write_reg_w_i))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic en);
        return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    assign forward_a_e_o = fwd_e(rs_e_i);
    assign forward_b_e_o = fwd_e(rt_e_i);
    assign forward_a_d_o = reg_write_m_i && src_hit(rs_d_i, write_reg_m_i);
    assign forward_b_d_o = reg_write_m_i && src_hit(rt_d_i, write_reg_m_i);

    assign md_busy_o = (state == BUSY);
    assign md_done_o = (state == BUSY) && (cnt == 4'd0);

    assign lw_stall = mem_to_reg_e_i && (write_reg_e_i != '0) &&
                      ((rs_d_i == write_reg_e_i) || (rt_d_i == write_reg_e_i));

    assign is_branch = (branch_d_i != 2'b00) || jump_d_i[1];
    assign br_hit_e  = reg_write_e_i &&
                       (src_hit(rs_d_i, write_reg_e_i) || src_hit(rt_d_i, write_reg_e_i));
    assign br_hit_m  = mem_to_reg_m_i &&
                       (src_hit(rs_d_i, write_reg_m_i) || src_hit(rt_d_i, write_reg_m_i));
    assign br_stall  = is_branch && (br_hit_e || br_hit_m);

    // The write-back cycle still stalls a dependent reader: the value is
    // only visible in the register file from the following cycle.
    assign sb_stall = md_busy_o && (pend_dest != '0) &&
                      ((rs_d_i == pend_dest) || (rt_d_i == pend_dest));

    // In the done cycle the unit is free for the next issue.
    assign st_stall = md_start_d_i && md_busy_o && !md_done_o;

    assign stall_d_o = lw_stall || br_stall || sb_stall || st_stall;
    assign stall_f_o = stall_d_o;
    assign flush_e_o = stall_d_o;
    assign flush_d_o = (pc_src_d_i || (jump_d_i != 3'b000)) && !stall_d_o;

    always_comb begin
        stall_cause_o = 3'd0;
        if (lw_stall)
            stall_cause_o = 3'd1;
        else if (br_stall)
            stall_cause_o = 3'd2;
        else if (sb_stall)
            stall_cause_o = 3'd3;
        else if (st_stall)
            stall_cause_o = 3'd4;
    end

    // An issue while BUSY with cnt != 0 is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend_dest <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_e_i) begin
                        state     <= BUSY;
                        cnt       <= CNT_LOAD;
                        pend_dest <= md_dest_e_i;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (md_start_e_i) begin
                        cnt       <= CNT_LOAD;
                        pend_dest <= md_dest_e_i;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lw_o <= '0;
            perf_br_o <= '0;
            perf_sb_o <= '0;
            perf_st_o <= '0;
        end else if (perf_clr_i) begin
            perf_lw_o <= '0;
            perf_br_o <= '0;
            perf_sb_o <= '0;
            perf_st_o <= '0;
        end else begin
            perf_lw_o <= sat_inc(perf_lw_o, lw_stall);
            perf_br_o <= sat_inc(perf_br_o, br_stall);
            perf_sb_o <= sat_inc(perf_sb_o, sb_stall);
            perf_st_o <= sat_inc(perf_st_o, st_stall);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit. Narrow counters so saturation is reachable.
module tb_hazard_scoreboard_unit;

    localparam int AW   = 6;
    localparam int LAT  = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst;
    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, md_dest, wr_m, wr_w;
    logic [1:0]    branch_d;
    logic          pc_src_d;
    logic [2:0]    jump_d;
    logic          md_start_d, mtr_e, rw_e, md_start_e, mtr_m, rw_m, rw_w, perf_clr;
    logic          stall_f, stall_d, flush_d, flush_e, fad, fbd, md_busy, md_done;
    logic [1:0]    fae, fbe;
    logic [2:0]    cause;
    logic [CW-1:0] p_lw, p_br, p_sb, p_st;

    hazard_scoreboard_unit #(.ADDR_W(AW), .MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs_d_i(rs_d), .rt_d_i(rt_d), .branch_d_i(branch_d), .pc_src_d_i(pc_src_d),
        .jump_d_i(jump_d), .md_start_d_i(md_start_d),
        .rs_e_i(rs_e), .rt_e_i(rt_e), .write_reg_e_i(wr_e),
        .mem_to_reg_e_i(mtr_e), .reg_write_e_i(rw_e),
        .md_start_e_i(md_start_e), .md_dest_e_i(md_dest),
        .write_reg_m_i(wr_m), .mem_to_reg_m_i(mtr_m), .reg_write_m_i(rw_m),
        .write_reg_w_i(wr_w), .reg_write_w_i(rw_w), .perf_clr_i(perf_clr),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_d_o(flush_d), .flush_e_o(flush_e),
        .forward_a_d_o(fad), .forward_b_d_o(fbd),
        .forward_a_e_o(fae), .forward_b_e_o(fbe),
        .stall_cause_o(cause), .md_busy_o(md_busy), .md_done_o(md_done),
        .perf_lw_o(p_lw), .perf_br_o(p_br), .perf_sb_o(p_sb), .perf_st_o(p_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       lw, br, sb, st;
        logic       stall, flush_d, fad, fbd;
        logic [1:0] fae, fbe;
        logic [2:0] cause;
        logic       busy, done;
        int         clw, cbr, csb, cst;
    } exp_t;

    exp_t q[$];

    // Reference state
    logic          m_busy;
    int            m_rem;
    logic [AW-1:0] m_pend;
    int            c_lw, c_br, c_sb, c_st;

    function automatic logic hit(input logic [AW-1:0] s, input logic [AW-1:0] d);
        return (s != 0) && (s == d);
    endfunction

    function automatic logic [1:0] mfwd(input logic [AW-1:0] s);
        if (rw_m && hit(s, wr_m)) return 2'b10;
        if (rw_w && hit(s, wr_w)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.lw    = mtr_e && (wr_e != 0) && (rs_d == wr_e || rt_d == wr_e);
        e.br    = ((branch_d != 0) || jump_d[1]) &&
                  ((rw_e && (hit(rs_d, wr_e) || hit(rt_d, wr_e))) ||
                   (mtr_m && (hit(rs_d, wr_m) || hit(rt_d, wr_m))));
        e.done  = m_busy && (m_rem == 0);
        e.busy  = m_busy;
        e.sb    = m_busy && (m_pend != 0) && (rs_d == m_pend || rt_d == m_pend);
        e.st    = md_start_d && m_busy && !e.done;
        e.stall = e.lw | e.br | e.sb | e.st;
        e.flush_d = (pc_src_d || jump_d != 0) && !e.stall;
        e.cause = e.lw ? 3'd1 : e.br ? 3'd2 : e.sb ? 3'd3 : e.st ? 3'd4 : 3'd0;
        e.fae   = mfwd(rs_e);
        e.fbe   = mfwd(rt_e);
        e.fad   = rw_m && hit(rs_d, wr_m);
        e.fbd   = rw_m && hit(rt_d, wr_m);
        e.clw = c_lw; e.cbr = c_br; e.csb = c_sb; e.cst = c_st;
        return e;
    endfunction

    function automatic int sat(input int c, input logic en);
        return (en && c < CMAX) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_rem = 0; m_pend = 0;
        c_lw = 0; c_br = 0; c_sb = 0; c_st = 0;
        q.delete();
    endtask

    // One clock: push expectation, compare at negedge, advance model at posedge.
    task automatic step();
        exp_t e, g;
        e = model();
        q.push_back(e);
        @(negedge clk);
        g = q.pop_front();
        chk("stall_f", stall_f, g.stall);
        chk("stall_d", stall_d, g.stall);
        chk("flush_e", flush_e, g.stall);
        chk("flush_d", flush_d, g.flush_d);
        chk("stall_cause", cause, g.cause);
        chk("fwd_a_e", fae, g.fae);
        chk("fwd_b_e", fbe, g.fbe);
        chk("fwd_a_d", fad, g.fad);
        chk("fwd_b_d", fbd, g.fbd);
        chk("md_busy", md_busy, g.busy);
        chk("md_done", md_done, g.done);
        chk("perf_lw", p_lw, g.clw);
        chk("perf_br", p_br, g.cbr);
        chk("perf_sb", p_sb, g.csb);
        chk("perf_st", p_st, g.cst);
        @(posedge clk);
        if (perf_clr) begin
            c_lw = 0; c_br = 0; c_sb = 0; c_st = 0;
        end else begin
            c_lw = sat(c_lw, e.lw); c_br = sat(c_br, e.br);
            c_sb = sat(c_sb, e.sb); c_st = sat(c_st, e.st);
        end
        if (!m_busy) begin
            if (md_start_e) begin m_busy = 1; m_rem = LAT - 1; m_pend = md_dest; end
        end else if (m_rem != 0) begin
            m_rem--;
        end else if (md_start_e) begin
            m_rem = LAT - 1; m_pend = md_dest;
        end else begin
            m_busy = 0;
        end
        #1;
    endtask

    task automatic idle_in();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; md_dest = 0; wr_m = 0; wr_w = 0;
        branch_d = 0; pc_src_d = 0; jump_d = 0; md_start_d = 0; mtr_e = 0; rw_e = 0;
        md_start_e = 0; mtr_m = 0; rw_m = 0; rw_w = 0; perf_clr = 0;
    endtask

    task automatic clear_counters();
        perf_clr = 1; step(); perf_clr = 0;
    endtask

    // Issuing while an op is still counting down is an integration error.
    always @(negedge clk)
        if (!rst && md_start_e)
            chk("issue_while_busy", 64'(md_busy & ~md_done), 0);

    initial begin
        idle_in();
        rst = 1;
        model_reset();
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        chk("rst_perf_lw", p_lw, 0);
        chk("rst_perf_sb", p_sb, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // Forwarding
        rs_e = 5; wr_m = 5; rw_m = 1; wr_w = 5; rw_w = 1; #1;
        chk("fwd_a_e_m_prio", fae, 2'b10);
        step();
        rw_m = 0; #1;
        chk("fwd_a_e_w", fae, 2'b01);
        step();
        rs_e = 0; #1;
        chk("fwd_a_e_zero", fae, 2'b00);
        step();
        rt_e = 7; wr_w = 7; step();
        rs_d = 4; rt_d = 4; wr_m = 4; rw_m = 1; step();
        idle_in(); step();

        // Load-use
        clear_counters();
        mtr_e = 1; wr_e = 8; rt_d = 8; #1;
        chk("lw_stall", stall_d, 1);
        chk("lw_cause", cause, 3'd1);
        repeat (3) step();
        chk("lw_count3", p_lw, 3);
        wr_e = 0; #1;
        chk("lw_r0_nostall", stall_d, 0);
        step();
        idle_in(); step();

        // Branch hazard, then taken branch flushes once clear
        branch_d = 1; pc_src_d = 1; rw_e = 1; wr_e = 3; rs_d = 3; #1;
        chk("br_cause", cause, 3'd2);
        chk("br_no_flush", flush_d, 0);
        step();
        rw_e = 0; #1;
        chk("br_flush", flush_d, 1);
        step();
        idle_in();
        jump_d = 3'b010; mtr_m = 1; wr_m = 9; rt_d = 9; step();
        mtr_e = 1; wr_e = 9; rw_e = 1; step();   // lw and branch stalls together
        idle_in(); step();

        // Scoreboard
        clear_counters();
        md_start_e = 1; md_dest = 33; rs_d = 33; step();
        md_start_e = 0;
        repeat (3) step();
        #1;
        chk("sb_done_c4", md_done, 1);
        chk("sb_stall_c4", stall_d, 1);
        step();
        chk("sb_nostall_c5", stall_d, 0);
        chk("sb_count", p_sb, 4);
        step();
        idle_in(); step();

        // Structural plus back-to-back issue
        clear_counters();
        md_start_e = 1; md_dest = 33; rs_d = 2; step();
        md_start_e = 0; md_start_d = 1;
        #1;
        chk("st_cause", cause, 3'd4);
        repeat (3) step();
        md_start_e = 1; md_dest = 32; #1;
        chk("st_done_c4", md_done, 1);
        chk("st_none_c4", stall_d, 0);
        step();
        md_start_e = 0; md_start_d = 0;
        repeat (3) step();
        chk("b2b_done_c8", md_done, 1);
        chk("st_count", p_st, 3);
        step();
        step();

        // Reset mid-BUSY
        md_start_e = 1; md_dest = 33; rs_d = 33; step();
        md_start_e = 0; step();
        chk("pre_rst_busy", md_busy, 1);
        rst = 1; #1;
        chk("rst_mid_busy", md_busy, 0);
        chk("rst_mid_lw", p_lw, 0);
        chk("rst_mid_sb", p_sb, 0);
        chk("rst_mid_st", p_st, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        step();

        // Saturation and clear priority
        idle_in();
        mtr_e = 1; wr_e = 8; rs_d = 8;
        repeat (CMAX + 5) step();
        chk("sat_hold", p_lw, CMAX);
        perf_clr = 1; step();
        perf_clr = 0; #1;
        chk("clr_during_stall", p_lw, 0);
        step();
        idle_in(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Next-generation pipeline hazard unit for the 5-stage MIPS core.
- Keeps the existing forwarding and stall logic for load-use and branch/jr hazards.
- Adds a register scoreboard and FSM for one outstanding multi-cycle multiply/divide op (MDU) of parametrised latency.
- Adds saturating per-cause stall performance counters.
- Sits beside the datapath; drives stage stall, flush and forward controls.

Parameters:
- ADDR_W, 6, register index width; indices 32/33 are HI/LO; index 0 never causes a hazard.
- MD_LATENCY, 4, cycles from MDU issue in E until the result is written; legal range 1..15.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- rs_d_i, rt_d_i  in  ADDR_W  source registers in D
- branch_d_i  in  2  branch type in D; nonzero means branch
- pc_src_d_i  in  1  branch taken in D
- jump_d_i  in  3  jump type in D; bit 1 means jr/jalr
- md_start_d_i  in  1  D holds an MDU instruction
- rs_e_i, rt_e_i  in  ADDR_W  source registers in E
- write_reg_e_i  in  ADDR_W  destination register in E
- mem_to_reg_e_i, reg_write_e_i  in  1  E control
- md_start_e_i  in  1  MDU op issuing from E this cycle
- md_dest_e_i  in  ADDR_W  register the MDU op writes
- write_reg_m_i  in  ADDR_W; mem_to_reg_m_i, reg_write_m_i  in  1  M stage
- write_reg_w_i  in  ADDR_W; reg_write_w_i  in  1  W stage
- perf_clr_i  in  1  synchronous clear of all counters
- stall_f_o, stall_d_o, flush_d_o, flush_e_o  out  1  pipeline control
- forward_a_d_o, forward_b_d_o  out  1  D-stage forward from M
- forward_a_e_o, forward_b_e_o  out  2  E-stage forward: 10 from M, 01 from W, 00 none
- stall_cause_o  out  3  0 none, 1 load-use, 2 branch, 3 scoreboard, 4 structural
- md_busy_o  out  1  MDU op outstanding
- md_done_o  out  1  one-cycle pulse: MDU result written this cycle
- perf_lw_o, perf_br_o, perf_sb_o, perf_st_o  out  CNT_W  stall-cycle counters

Behaviour:
- E forwarding: M has priority over W. A match requires source != 0, equal index and the matching reg_write. D forwarding is from M only, same rules.
- lw_stall: mem_to_reg_e_i, write_reg_e_i != 0, and rs_d_i or rt_d_i equals write_reg_e_i.
- br_stall: (branch_d_i != 0 or jump_d_i[1]) and either:
  - reg_write_e_i with a nonzero D-source match on write_reg_e_i, or
  - mem_to_reg_m_i with a nonzero D-source match on write_reg_m_i.
- sb_stall: md_busy_o, pend_dest != 0, and rs_d_i or rt_d_i equals pend_dest. This includes the md_done_o cycle.
- st_stall: md_start_d_i and md_busy_o and not md_done_o.
- stall_d_o = OR of the four stalls; stall_f_o = flush_e_o = stall_d_o.
- flush_d_o = (pc_src_d_i or jump_d_i != 0) and not stall_d_o. A stalled branch must not flush.
- stall_cause_o priority: lw > branch > scoreboard > structural; 0 when no stall.
- FSM states IDLE, BUSY:
  - IDLE with md_start_e_i: go to BUSY, load cnt = MD_LATENCY-1, latch pend_dest = md_dest_e_i.
  - BUSY with cnt != 0: cnt decrements each cycle.
  - BUSY with cnt == 0: md_done_o = 1 (combinational from state). Next state is BUSY reloaded if md_start_e_i is high that cycle (back-to-back issue), else IDLE.
  - md_start_e_i in BUSY with cnt != 0 is an integration error. Ignore it and hold state; assertion in the bench.
  - MD_LATENCY=1: BUSY lasts exactly one cycle with md_done_o high.
- md_busy_o = (state == BUSY).
- Counters: each increments by 1 per cycle its stall is active. All simultaneous active causes are counted, not just the highest-priority one.
  - Counters saturate at all-ones.
  - perf_clr_i zeroes all counters and has priority over increment.
- Reset (async, any time including mid-BUSY): state IDLE, cnt 0, pend_dest 0, md_busy_o 0, md_done_o 0, all counters 0. Combinational outputs follow inputs immediately.

Test Plan:
- Forwarding: rs_e=5, write_reg_m=5, reg_write_m=1, write_reg_w=5, reg_write_w=1 -> forward_a_e=10. Drop reg_write_m -> 01. rs_e=0 -> 00.
- Load-use: mem_to_reg_e=1, write_reg_e=8, rt_d=8 -> stall_f/d=1, flush_e=1, stall_cause=1, perf_lw +1 per cycle. write_reg_e=0 -> no stall.
- Branch: branch_d=1, pc_src_d=1, reg_write_e=1, write_reg_e=rs_d=3 -> stall_cause=2, flush_d=0. Next cycle with no hazard -> flush_d=1.
- Scoreboard, MD_LATENCY=4: md_start_e, md_dest=33 at cycle 0; rs_d=33 -> stall in cycles 1-4, md_done_o in cycle 4, no stall in cycle 5, perf_sb=4.
- Structural plus back-to-back: md_start_d=1 in cycles 1-3 -> stall_cause=4. At cycle 4 (done) no structural stall. md_start_e at cycle 4 -> busy continues, next done at cycle 8.
- Reset mid-BUSY at cycle 2 -> md_busy_o=0 immediately, all counters 0. Saturation: preload counter to all-ones, stall -> holds. perf_clr_i during a stall -> counter 0.
